// File: rtl/fpu_exp_pkg.sv
// Shared FPU exponent-path definitions.
//   EXP_W       exponent width (biased, unsigned)
//   EXP_SHW     alignment shift-count width
//   exp_align_t result bundle held in the align unit's output register
package fpu_exp_pkg;

  localparam int EXP_W   = 14;
  localparam int EXP_SHW = 6;

  typedef struct packed {
    logic [EXP_W-1:0]   emax;
    logic [EXP_W-1:0]   diff;
    logic [EXP_SHW-1:0] shamt;
    logic               swap;
    logic               eq;
  } exp_align_t;

endpackage

// File: rtl/exp_prefix_sub.sv
// Combinational Sklansky-prefix subtractor: d = a - b = a + ~b + 1.
// Ports:
//   a, b  in  WIDTH  unsigned operands
//   d     out WIDTH  difference modulo 2^WIDTH
//   cout  out 1      carry-out; 1 means a >= b
module exp_prefix_sub #(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             cout
);

  localparam int LV = $clog2(WIDTH);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prp;
  logic [WIDTH-1:0] gpre;

  assign gen = a & ~b;
  assign prp = a ^ ~b;

  // Forced carry-in of 1 is folded into bit 0's generate, so every prefix
  // group that reaches bit 0 is a complete carry into the next position.
  always_comb begin : prefix_tree
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    int               j;
    g    = gen;
    p    = prp;
    g[0] = gen[0] | prp[0];
    j    = 0;
    // Each level merges the upper half of every 2^(l+1) block with the top
    // bit of its lower half. Only upper-half bits change, so the in-place
    // update never reads a value already modified at this level.
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          j    = ((i >> l) << l) - 1;
          g[i] = g[i] | (p[i] & g[j]);   // grey/black cell generate
          p[i] = p[i] & p[j];            // black cell propagate
        end
      end
    end
    gpre = g;
  end

  // Carry into bit i is the group generate of bits [i-1:0]; bit 0 gets cin=1.
  assign d    = prp ^ {gpre[WIDTH-2:0], 1'b1};
  assign cout = gpre[WIDTH-1];

endmodule

// File: rtl/exp_sub_align.sv
// Two-stage exponent subtract/align unit for the FP adder front end.
// S1 subtracts eb from ea through the prefix subtractor; S2 picks the larger
// exponent, forms |ea-eb|, and derives swap/eq and the shifter count.
// Build option: define EXP_SUB_ALIGN_SAT_EN to saturate shamt at 2^SHW-1
// instead of truncating diff to SHW bits.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   ea, eb              biased exponents
//   out_valid/out_ready result handshake, full backpressure
//   emax, diff, shamt   max exponent, |ea-eb|, alignment shift count
//   swap, eq            eb > ea, ea == eb
module exp_sub_align
  import fpu_exp_pkg::*;
#(
  parameter int WIDTH = EXP_W,
  parameter int SHW   = EXP_SHW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] emax,
  output logic [WIDTH-1:0] diff,
  output logic [SHW-1:0]   shamt,
  output logic             swap,
  output logic             eq
);

  function automatic logic [SHW-1:0] align_shamt(input logic [WIDTH-1:0] dv);
`ifdef EXP_SUB_ALIGN_SAT_EN
    if (dv > WIDTH'((1 << SHW) - 1)) return {SHW{1'b1}};
    else                             return dv[SHW-1:0];
`else
    return dv[SHW-1:0];
`endif
  endfunction

  logic             vld_p1, vld_p2;
  logic             adv_p1, adv_p2;
  logic [WIDTH-1:0] d_p0;
  logic             cout_p0;
  logic [WIDTH-1:0] d_p1, ea_p1, eb_p1;
  logic             borrow_p1;
  exp_align_t       res_p1, res_p2;

  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = reset_n && adv_p1;

  // ---- S1: subtract ----
  exp_prefix_sub #(.WIDTH(WIDTH)) u_sub (
    .a    (ea),
    .b    (eb),
    .d    (d_p0),
    .cout (cout_p0)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) begin
      d_p1      <= d_p0;
      borrow_p1 <= ~cout_p0;
      ea_p1     <= ea;
      eb_p1     <= eb;
    end
  end

  // ---- S2: select, negate, register results ----
  always_comb begin
    res_p1       = '0;
    res_p1.swap  = borrow_p1;
    res_p1.emax  = borrow_p1 ? eb_p1 : ea_p1;
    res_p1.diff  = borrow_p1 ? (~d_p1 + {{(WIDTH-1){1'b0}}, 1'b1}) : d_p1;
    res_p1.eq    = (d_p1 == '0);
    res_p1.shamt = align_shamt(res_p1.diff);
  end

  // Output data is reset too so nothing stale is visible after a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) res_p2 <= res_p1;
    end
  end

  assign out_valid = vld_p2;
  assign emax      = res_p2.emax;
  assign diff      = res_p2.diff;
  assign shamt     = res_p2.shamt;
  assign swap      = res_p2.swap;
  assign eq        = res_p2.eq;

endmodule
